// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// ----------------------------------------------------------------------------
// Shares the single memory/MMIO port of the mmu between two requesters: the
// instruction-fetch port (if_*) and the load/store port (d_*). The block
// handles one transaction at a time. It holds the m_* signals bit-stable while
// the mmu stalls, and it returns the read data to the requester that won.
//
// Transaction flow: IDLE (grant) -> ACCESS (m_* driven, wait on m_wait)
//                   -> RESP (rvalid pulse) -> IDLE
// With m_wait low, a grant in cycle N produces rvalid in cycle N+2.
//
// Ports
//   clock, RST                 clock and synchronous active-high reset
//   if_req/if_addr             fetch request, held high until if_gnt
//   if_gnt/if_rvalid/if_rdata  fetch grant pulse, data-valid pulse, data
//   d_req/d_we/d_addr/         load/store request, held high until d_gnt
//   d_wdata/d_be
//   d_gnt/d_rvalid/d_rdata     load/store grant pulse, response pulse, data
//                              (d_rdata is 0 on a store acknowledge)
//   m_addr/m_wdata/m_be/m_we   to mmu vaddr/data/byteena/memWE
//   m_wait/m_rdata             from mmu memWait/q (q is valid one cycle
//                              after the access is accepted)
//   busy                       high whenever a transaction is in flight
//
// Parameters
//   STARVE_LIMIT  consecutive data grants allowed while a fetch is pending
//                 before the fetch is forced through (1..15)
//
// Configuration macro
//   MEM_ARB_ROUND_ROBIN_EN  when defined, the two requesters alternate under
//                           contention. The starvation counter is removed.
//                           When undefined, data has priority and the
//                           starvation limit applies.
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        RST,

  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,

  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,

  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_be,
  output logic        m_we,
  input  logic        m_wait,
  input  logic [31:0] m_rdata,

  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state;
  logic        lat_is_d;     // winner of the in-flight transaction
  logic        lat_we;       // the in-flight transaction is a store
  logic [31:0] if_rdata_q;   // last delivered fetch data
  logic [31:0] d_rdata_q;    // last delivered load data / store ack

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic        last_d;       // 1: data won the previous grant, 0: fetch did
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0]  starve_cnt;
`endif

  // Arbitration. Grants are issued only in IDLE and never in a reset cycle.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (state == IDLE && !RST) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (if_req && d_req) begin
        if (last_d) if_gnt = 1'b1;
        else        d_gnt  = 1'b1;
      end else begin
        if_gnt = if_req;
        d_gnt  = d_req;
      end
`else
      // Data wins unless the pending fetch has been passed over LIMIT times.
      if (d_req && !(if_req && starve_cnt == LIMIT)) d_gnt  = 1'b1;
      else if (if_req)                               if_gnt = 1'b1;
`endif
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clock) begin
    if (RST)         last_d <= 1'b0;
    else if (if_gnt) last_d <= 1'b0;
    else if (d_gnt)  last_d <= 1'b1;
  end
`else
  // The counter is cleared whenever no fetch is waiting. It saturates as a
  // guard, although the forced fetch normally keeps it at or below LIMIT.
  always_ff @(posedge clock) begin
    if (RST)                     starve_cnt <= 4'd0;
    else if (!if_req || if_gnt)  starve_cnt <= 4'd0;
    else if (d_gnt && starve_cnt != 4'hF)
                                 starve_cnt <= starve_cnt + 4'd1;
  end
`endif

  // Sequencer. The m_* signals are registered so they stay bit-stable for
  // as long as m_wait holds the access.
  always_ff @(posedge clock) begin
    if (RST) begin
      state      <= IDLE;
      lat_is_d   <= 1'b0;
      lat_we     <= 1'b0;
      m_addr     <= 32'h0;
      m_wdata    <= 32'h0;
      m_be       <= 4'h0;
      m_we       <= 1'b0;
      if_rdata_q <= 32'h0;
      d_rdata_q  <= 32'h0;
    end else begin
      case (state)
        // IDLE -> ACCESS: latch the winner's request
        IDLE: begin
          if (d_gnt) begin
            state    <= ACCESS;
            lat_is_d <= 1'b1;
            lat_we   <= d_we;
            m_addr   <= d_addr;
            m_wdata  <= d_wdata;
            m_be     <= d_be;
            m_we     <= d_we;
          end else if (if_gnt) begin
            state    <= ACCESS;
            lat_is_d <= 1'b0;
            lat_we   <= 1'b0;
            m_addr   <= if_addr;
            m_wdata  <= 32'h0;
            m_be     <= 4'hF;
            m_we     <= 1'b0;
          end
        end
        // ACCESS -> RESP: the mmu accepts the access when m_wait drops
        ACCESS: begin
          if (!m_wait) begin
            state <= RESP;
            m_be  <= 4'h0;
            m_we  <= 1'b0;
          end
        end
        // RESP -> IDLE: capture the returned data so it holds afterwards
        RESP: begin
          state <= IDLE;
          if (lat_is_d) d_rdata_q  <= lat_we ? 32'h0 : m_rdata;
          else          if_rdata_q <= m_rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // m_rdata is valid only during RESP. It is forwarded in that cycle and the
  // captured copy is shown in every other cycle.
  assign if_rvalid = (state == RESP) && !lat_is_d && !RST;
  assign d_rvalid  = (state == RESP) &&  lat_is_d && !RST;
  assign if_rdata  = if_rvalid ? m_rdata : if_rdata_q;
  assign d_rdata   = d_rvalid ? (lat_we ? 32'h0 : m_rdata) : d_rdata_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        RST;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;
  logic        m_we, m_wait, busy;

  always #5 clock = ~clock;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clock(clock), .RST(RST),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_be(d_be), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be), .m_we(m_we),
    .m_wait(m_wait), .m_rdata(m_rdata), .busy(busy)
  );

  // Simple mmu read model: q is registered from the presented address.
  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h40:  rom = 32'h12345678;
      32'h44:  rom = 32'hCAFEF00D;
      32'h80:  rom = 32'hFFFFFFFF;
      32'h100: rom = 32'h0BADF00D;
      32'h200: rom = 32'h00000002;
      default: rom = 32'h0;
    endcase
  endfunction

  always @(posedge clock) m_rdata <= rom(m_addr);

  typedef struct packed {
    logic        is_d;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor / scoreboard
  always @(negedge clock) begin
    if (if_rvalid || d_rvalid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: if_rvalid=%0b d_rvalid=%0b expected none",
                 if_rvalid, d_rvalid);
      end else begin
        mon_e = sb.pop_front();
        check("rvalid_src", {30'b0, if_rvalid, d_rvalid}, mon_e.is_d ? 32'd1 : 32'd2);
        check("rdata", mon_e.is_d ? d_rdata : if_rdata, mon_e.data);
      end
    end
  end

  // Single uncontended read. The grant must come in the request cycle,
  // the access must follow in the next cycle, and rvalid must arrive at
  // grant+2.
  task automatic do_read(input logic is_d, input logic [31:0] addr,
                         input logic [31:0] exp, input string name);
    @(posedge clock); #1;
    if (is_d) begin
      d_req = 1'b1; d_we = 1'b0; d_addr = addr; d_be = 4'hF; d_wdata = 32'h0;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    @(negedge clock);
    check({name, "_gnt"}, {31'b0, is_d ? d_gnt : if_gnt}, 32'd1);
    sb.push_back({is_d, exp});
    @(posedge clock); #1;
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clock);
    check({name, "_maddr"}, m_addr, addr);
    check({name, "_mwe"}, {31'b0, m_we}, 32'd0);
    check({name, "_busy_acc"}, {31'b0, busy}, 32'd1);
    @(negedge clock);
    check({name, "_rvalid_lat"}, {31'b0, is_d ? d_rvalid : if_rvalid}, 32'd1);
    @(negedge clock);
    check({name, "_busy_done"}, {31'b0, busy}, 32'd0);
  endtask

  logic exp_seq [10];

  initial begin
    RST = 1'b1; if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
    d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0; m_wait = 1'b0;

    // Reset state, including a request that arrives during reset
    repeat (3) @(posedge clock);
    #1 if_req = 1'b1; if_addr = 32'h40;
    @(negedge clock);
    check("rst_if_gnt", {31'b0, if_gnt}, 32'd0);
    check("rst_d_gnt", {31'b0, d_gnt}, 32'd0);
    check("rst_rvalid", {30'b0, if_rvalid, d_rvalid}, 32'd0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    check("rst_m_addr", m_addr, 32'h0);
    check("rst_m_wdata", m_wdata, 32'h0);
    check("rst_m_be_we", {27'b0, m_be, m_we}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    @(posedge clock); #1;
    if_req = 1'b0; RST = 1'b0;

    // Fetch read of 0x40
    do_read(1'b0, 32'h40, 32'h12345678, "fetch");

    // Store with a three-cycle stall
    @(posedge clock); #1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
    m_wait = 1'b1;
    @(negedge clock);
    check("st_gnt", {31'b0, d_gnt}, 32'd1);
    sb.push_back({1'b1, 32'h0});
    for (int i = 1; i <= 4; i++) begin
      @(posedge clock); #1;
      d_req = 1'b0;
      if (i == 4) m_wait = 1'b0;
      @(negedge clock);
      check($sformatf("st_addr_c%0d", i), m_addr, 32'h80);
      check($sformatf("st_wdata_c%0d", i), m_wdata, 32'hDEADBEEF);
      check($sformatf("st_be_we_c%0d", i), {27'b0, m_be, m_we}, {27'b0, 4'b0011, 1'b1});
    end
    @(negedge clock);
    check("st_rvalid", {31'b0, d_rvalid}, 32'd1);
    check("st_resp_be_we", {27'b0, m_be, m_we}, 32'h0);
    @(negedge clock);
    check("st_after_we", {31'b0, m_we}, 32'd0);
    check("st_after_busy", {31'b0, busy}, 32'd0);

    // Reset during the ACCESS phase of a load to 0x100
    @(posedge clock); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_be = 4'hF; d_wdata = 32'h0;
    @(negedge clock);
    check("rmo_gnt", {31'b0, d_gnt}, 32'd1);
    @(posedge clock); #1;
    d_req = 1'b0; RST = 1'b1;
    @(negedge clock);
    @(posedge clock); #1;
    d_req = 1'b1;
    @(negedge clock);
    check("rmo_busy", {31'b0, busy}, 32'd0);
    check("rmo_be_we", {27'b0, m_be, m_we}, 32'h0);
    check("rmo_no_rvalid", {31'b0, d_rvalid}, 32'd0);
    check("rmo_no_gnt_in_rst", {31'b0, d_gnt}, 32'd0);
    @(posedge clock); #1;
    RST = 1'b0;
    @(negedge clock);
    check("rmo_reissue_gnt", {31'b0, d_gnt}, 32'd1);
    sb.push_back({1'b1, 32'h0BADF00D});
    @(posedge clock); #1;
    d_req = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("rmo_reissue_rvalid", {31'b0, d_rvalid}, 32'd1);
    @(negedge clock);

    // MMIO status read
    do_read(1'b1, 32'h200, 32'h00000002, "mmio");

    // Contention, starting from reset state
    @(posedge clock); #1 RST = 1'b1;
    @(posedge clock); #1 RST = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`endif
    for (int k = 0; k < 10; k++)
      sb.push_back({exp_seq[k], exp_seq[k] ? 32'hCAFEF00D : 32'h12345678});
    if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44; d_be = 4'hF; d_wdata = 32'h0;
    for (int k = 0; k < 10; k++) begin
      int   n;
      logic got;
      n = 0; got = 1'b0;
      while (n < 10 && !got) begin
        @(negedge clock);
        got = if_gnt || d_gnt;
        n++;
      end
      check($sformatf("arb_gnt%0d", k), got ? {31'b0, d_gnt} : 32'd2, {31'b0, exp_seq[k]});
      check($sformatf("arb_onehot%0d", k), {31'b0, if_gnt & d_gnt}, 32'd0);
    end
    @(posedge clock); #1;
    if_req = 1'b0; d_req = 1'b0;

    // Drain outstanding responses
    begin
      int n;
      n = 0;
      while (sb.size() != 0 && n < 20) begin
        @(negedge clock);
        n++;
      end
    end
    check("drain_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
